// File: rtl/fft_spectrum_pkg.sv
// Shared types and helpers for the FFT spectrum buffer: FSM states, pipeline depth
// and the alpha-max-beta-min magnitude approximation.
package fft_spectrum_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        CAPTURE  = 2'd1,
        COMMIT   = 2'd2
    } fsm_state_t;

    localparam int PIPE_DEPTH = 3;
    localparam int APPROX_W   = 32;

    typedef logic [APPROX_W-1:0] approx_in_t;
    typedef logic [APPROX_W+1:0] approx_out_t;

    // |z| ~= max + min/4 + min/8; the two extra bits absorb the growth.
    function automatic approx_out_t mag_approx(input approx_in_t a, input approx_in_t b);
        approx_out_t mx;
        approx_out_t mn;
        if (a >= b) begin
            mx = {2'b00, a};
            mn = {2'b00, b};
        end else begin
            mx = {2'b00, b};
            mn = {2'b00, a};
        end
        return mx + (mn >> 2) + (mn >> 3);
    endfunction

endpackage

// File: rtl/fft_spectrum_dpram.sv
// Simple dual-port spectrum RAM: one write port, one registered read port.
// Address MSB selects the ping-pong bank.
module fft_spectrum_dpram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 12
) (
    input  logic              i_aclk,
    input  logic              i_aresetn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 32'd1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Write port; array contents are not reset.
    always_ff @(posedge i_aclk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port, free-running so the display path ignores the clock enable.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            rdata_r <= {DATA_W{1'b0}};
        end else begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/fft_spectrum_buf.sv
// FFT output magnitude into a ping-pong spectrum RAM with a display read port.
// Define SPEC_PEAK_DETECT_EN to add lower-half peak bin/magnitude reporting.
module fft_spectrum_buf
    import fft_spectrum_pkg::*;
#(
    parameter int LOG2_FFT_LEN  = 8,
    parameter int OUTPUT_WIDTH  = 25,
    parameter int DATAOUT_WIDTH = 32,
    parameter int USER_WIDTH    = 16,
    parameter int MAG_WIDTH     = 12,
    parameter int MAG_SHIFT     = 8
) (
    input  logic                       i_aclk,
    input  logic                       i_aresetn,
    input  logic                       i_aclken,
    input  logic                       i_axi4s_data_tvalid,
    input  logic [2*DATAOUT_WIDTH-1:0] i_axi4s_data_tdata,
    input  logic                       i_axi4s_data_tlast,
    input  logic [USER_WIDTH-1:0]      i_axi4s_data_tuser,
    input  logic                       i_freeze,
    input  logic [LOG2_FFT_LEN-1:0]    i_rd_addr,
    output logic [MAG_WIDTH-1:0]       o_rd_data,
    output logic                       o_frame_done,
    output logic                       o_frame_err,
    output logic [15:0]                o_frame_cnt
`ifdef SPEC_PEAK_DETECT_EN
    ,
    output logic [LOG2_FFT_LEN-1:0]    o_peak_bin,
    output logic [MAG_WIDTH-1:0]       o_peak_mag
`endif
);

    localparam logic [LOG2_FFT_LEN-1:0] ZERO_IDX = {LOG2_FFT_LEN{1'b0}};
    localparam logic [LOG2_FFT_LEN-1:0] ONE_IDX  = {{(LOG2_FFT_LEN-1){1'b0}}, 1'b1};
    localparam logic [LOG2_FFT_LEN-1:0] LAST_BIN = {LOG2_FFT_LEN{1'b1}};
    localparam logic [OUTPUT_WIDTH-1:0] NEG_MIN  = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
    localparam logic [OUTPUT_WIDTH-1:0] ABS_MAX  = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic [MAG_WIDTH-1:0]    MAG_MAX  = {MAG_WIDTH{1'b1}};

    function automatic logic [OUTPUT_WIDTH-1:0] sat_abs(input logic [OUTPUT_WIDTH-1:0] x);
        logic [OUTPUT_WIDTH-1:0] r;
        if (x == NEG_MIN) begin
            r = ABS_MAX;
        end else if (x[OUTPUT_WIDTH-1]) begin
            r = ~x + {{(OUTPUT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = x;
        end
        return r;
    endfunction

    fsm_state_t                state_r, state_nxt_s;
    logic [LOG2_FFT_LEN-1:0]   exp_idx_r, exp_idx_nxt_s;
    logic [LOG2_FFT_LEN-1:0]   idx_s;
    logic                      beat_s, sof_s, accept_s, last_ok_s, err_s, commit_fire_s;

    logic                      s1_vld_r, s2_vld_r;
    logic [LOG2_FFT_LEN-1:0]   s1_idx_r, s2_idx_r;
    logic [OUTPUT_WIDTH-1:0]   s1_ar_r, s1_ai_r;
    logic [OUTPUT_WIDTH:0]     s2_m_r;
    logic [PIPE_DEPTH-2:0]     last_pipe_r;
    approx_out_t               m_full_s;
    logic [OUTPUT_WIDTH:0]     shifted_s;
    logic [MAG_WIDTH-1:0]      v_s;

    logic                      wbank_r, done_r, err_r;
    logic [15:0]               cnt_r;
    logic                      unused_s;

    assign idx_s         = i_axi4s_data_tuser[LOG2_FFT_LEN-1:0];
    assign beat_s        = i_aclken & i_axi4s_data_tvalid;
    assign sof_s         = beat_s && (idx_s == ZERO_IDX);
    assign commit_fire_s = i_aclken & last_pipe_r[PIPE_DEPTH-2];
    assign unused_s      = ^{i_axi4s_data_tdata[DATAOUT_WIDTH-1:OUTPUT_WIDTH],
                             i_axi4s_data_tdata[2*DATAOUT_WIDTH-1:DATAOUT_WIDTH+OUTPUT_WIDTH],
                             i_axi4s_data_tuser[USER_WIDTH-1:LOG2_FFT_LEN],
                             m_full_s[APPROX_W+1:OUTPUT_WIDTH+1]};

    // Frame sequencing on the incoming beat; commit itself rides the pipeline tag.
    always_comb begin
        state_nxt_s   = state_r;
        exp_idx_nxt_s = exp_idx_r;
        accept_s      = 1'b0;
        last_ok_s     = 1'b0;
        err_s         = 1'b0;
        case (state_r)
            WAIT_SOF: begin
                if (sof_s) begin
                    accept_s      = 1'b1;
                    state_nxt_s   = CAPTURE;
                    exp_idx_nxt_s = ONE_IDX;
                end else begin
                    state_nxt_s   = WAIT_SOF;
                end
            end
            CAPTURE: begin
                if (beat_s) begin
                    if ((idx_s != exp_idx_r) || (i_axi4s_data_tlast != (idx_s == LAST_BIN))) begin
                        err_s       = 1'b1;
                        state_nxt_s = WAIT_SOF;
                    end else if (idx_s == LAST_BIN) begin
                        accept_s    = 1'b1;
                        last_ok_s   = 1'b1;
                        state_nxt_s = COMMIT;
                    end else begin
                        accept_s      = 1'b1;
                        exp_idx_nxt_s = exp_idx_r + ONE_IDX;
                    end
                end else begin
                    state_nxt_s = CAPTURE;
                end
            end
            COMMIT: begin
                // A fresh frame may start before the previous one has drained.
                if (sof_s) begin
                    accept_s      = 1'b1;
                    state_nxt_s   = CAPTURE;
                    exp_idx_nxt_s = ONE_IDX;
                end else if (commit_fire_s) begin
                    state_nxt_s = WAIT_SOF;
                end else begin
                    state_nxt_s = COMMIT;
                end
            end
            default: begin
                state_nxt_s = WAIT_SOF;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_r   <= WAIT_SOF;
            exp_idx_r <= ZERO_IDX;
        end else if (i_aclken) begin
            state_r   <= state_nxt_s;
            exp_idx_r <= exp_idx_nxt_s;
        end
    end

    assign m_full_s = mag_approx(approx_in_t'(s1_ar_r), approx_in_t'(s1_ai_r));

    // Magnitude pipeline stages S1 and S2 with their sideband tags.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            s1_vld_r    <= 1'b0;
            s1_idx_r    <= ZERO_IDX;
            s1_ar_r     <= {OUTPUT_WIDTH{1'b0}};
            s1_ai_r     <= {OUTPUT_WIDTH{1'b0}};
            s2_vld_r    <= 1'b0;
            s2_idx_r    <= ZERO_IDX;
            s2_m_r      <= {(OUTPUT_WIDTH+1){1'b0}};
            last_pipe_r <= {(PIPE_DEPTH-1){1'b0}};
        end else if (i_aclken) begin
            s1_vld_r    <= accept_s;
            s1_idx_r    <= idx_s;
            s1_ar_r     <= sat_abs(i_axi4s_data_tdata[OUTPUT_WIDTH-1:0]);
            s1_ai_r     <= sat_abs(i_axi4s_data_tdata[DATAOUT_WIDTH+OUTPUT_WIDTH-1:DATAOUT_WIDTH]);
            s2_vld_r    <= s1_vld_r;
            s2_idx_r    <= s1_idx_r;
            s2_m_r      <= m_full_s[OUTPUT_WIDTH:0];
            last_pipe_r <= {last_pipe_r[PIPE_DEPTH-3:0], last_ok_s};
        end
    end

    // S3: scale and saturate ahead of the RAM write.
    always_comb begin
        shifted_s = s2_m_r >> MAG_SHIFT;
        if (|shifted_s[OUTPUT_WIDTH:MAG_WIDTH]) begin
            v_s = MAG_MAX;
        end else begin
            v_s = shifted_s[MAG_WIDTH-1:0];
        end
    end

    // Bank swap and frame status; the final write lands in the old bank on this same edge.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            wbank_r <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            cnt_r   <= 16'd0;
        end else begin
            done_r <= commit_fire_s & ~i_freeze;
            err_r  <= err_s;
            if (commit_fire_s && !i_freeze) begin
                wbank_r <= ~wbank_r;
                cnt_r   <= cnt_r + 16'd1;
            end
        end
    end

    assign o_frame_done = done_r;
    assign o_frame_err  = err_r;
    assign o_frame_cnt  = cnt_r;

    fft_spectrum_dpram #(
        .ADDR_W (LOG2_FFT_LEN + 1),
        .DATA_W (MAG_WIDTH)
    ) u_dpram (
        .i_aclk    (i_aclk),
        .i_aresetn (i_aresetn),
        .we        (i_aclken & s2_vld_r),
        .waddr     ({wbank_r, s2_idx_r}),
        .wdata     (v_s),
        .raddr     ({~wbank_r, i_rd_addr}),
        .rdata     (o_rd_data)
    );

`ifdef SPEC_PEAK_DETECT_EN
    localparam logic [LOG2_FFT_LEN-1:0] HALF_BIN = {1'b1, {(LOG2_FFT_LEN-1){1'b0}}};

    logic [LOG2_FFT_LEN-1:0] run_bin_r, peak_bin_r;
    logic [MAG_WIDTH-1:0]    run_mag_r, peak_mag_r;
    logic                    in_band_s;

    assign in_band_s = (s2_idx_r != ZERO_IDX) && (s2_idx_r < HALF_BIN);

    // Running lower-half peak, restarted by each frame's DC bin; strict compare keeps the lower bin on ties.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            run_bin_r  <= ZERO_IDX;
            run_mag_r  <= {MAG_WIDTH{1'b0}};
            peak_bin_r <= ZERO_IDX;
            peak_mag_r <= {MAG_WIDTH{1'b0}};
        end else begin
            if (i_aclken && s2_vld_r && (s2_idx_r == ZERO_IDX)) begin
                run_bin_r <= ZERO_IDX;
                run_mag_r <= {MAG_WIDTH{1'b0}};
            end else if (i_aclken && s2_vld_r && in_band_s && (v_s > run_mag_r)) begin
                run_bin_r <= s2_idx_r;
                run_mag_r <= v_s;
            end
            if (commit_fire_s && !i_freeze) begin
                peak_bin_r <= run_bin_r;
                peak_mag_r <= run_mag_r;
            end
        end
    end

    assign o_peak_bin = peak_bin_r;
    assign o_peak_mag = peak_mag_r;
`endif

endmodule
